// File: rtl/int_multiplier_seq.sv
// Sequential 4x4 shift-add multiplier with remainder add: uo_out = A*B + R.
// Level start/done handshake on uio pins; err flags triples that are not
// a valid division result (B == 0 or R >= B).
module int_multiplier_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  a_reg;
  logic [3:0]  b_reg;
  logic [7:0]  acc;
  logic [7:0]  acc_next;
  logic [7:0]  part_prod;
  logic [1:0]  count;
  logic [7:0]  result;
  logic        busy;
  logic        done;
  logic        err;
  logic        start;
  logic        unused_uio;

  assign start      = uio_in[4];
  assign unused_uio = &{1'b0, uio_in[7:5]};

  assign uo_out  = result;
  assign uio_out = {err, done, busy, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

  // Partial product for the current step, zero-extended before the shift.
  always_comb begin
    part_prod = {4'b0000, b_reg} << count;
    acc_next  = acc;
    if (a_reg[count]) acc_next = acc + part_prod;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; ena = 0 holds the current state.
  always_comb begin
    state_next = state;
    if (ena) begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (count == 2'd3) state_next = WAIT;
        WAIT:    if (!start) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand capture, accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= ui_in[7:4];
            b_reg <= ui_in[3:0];
            acc   <= {4'b0000, uio_in[3:0]};
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= (ui_in[3:0] == 4'd0) | (uio_in[3:0] >= ui_in[3:0]);
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + 2'd1;
          if (count == 2'd3) begin
            result <= acc_next;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_multiplier_seq.sv
// Directed self-checking bench for int_multiplier_seq.
module tb_int_multiplier_seq;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;
  logic [7:0] prev_res;

  int_multiplier_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Idle cycle with start low, then raise start with operands; checks after E0.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] r, input logic e);
    @(negedge clk);
    uio_in[4] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ui_in  = {a, b};
    uio_in = {3'b000, 1'b1, r};
    @(posedge clk);
    #1;
    chk("e0_busy_done", {6'b0, uio_out[6:5]}, 8'h01);
    chk("e0_err",       {7'b0, uio_out[7]},   {7'b0, e});
    chk("e0_uo_prev",   uo_out,               prev_res);
  endtask

  // Four RUN edges; hold keeps start high and scrambles the input pins.
  task automatic finish_op(input logic [7:0] exp, input logic e, input logic hold);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold) begin
          ui_in       = 8'hFF;
          uio_in[3:0] = 4'hF;
        end else begin
          uio_in[4] = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (i < 4) begin
        chk("run_busy_done", {6'b0, uio_out[6:5]}, 8'h01);
        chk("run_uo_prev",   uo_out,               prev_res);
      end else begin
        chk("res_value", uo_out,  exp);
        chk("res_flags", uio_out, {e, 1'b1, 1'b0, 5'b0});
      end
    end
    prev_res = exp;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    prev_res = 8'h00;
    rst_n    = 1'b0;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;

    // Reset state
    #12;
    chk("rst_uo",  uo_out,  8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe",  uio_oe,  8'hE0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: 7*3+2 = 23
    start_op(4'd7, 4'd3, 4'd2, 1'b0);
    finish_op(8'd23, 1'b0, 1'b0);

    // Max valid and max overall
    start_op(4'd15, 4'd15, 4'd14, 1'b0);
    finish_op(8'd239, 1'b0, 1'b0);
    start_op(4'd15, 4'd15, 4'd15, 1'b1);
    finish_op(8'd240, 1'b1, 1'b0);

    // Invalid triples
    start_op(4'd4, 4'd3, 4'd5, 1'b1);
    finish_op(8'd17, 1'b1, 1'b0);
    start_op(4'd9, 4'd0, 4'd6, 1'b1);
    finish_op(8'd6, 1'b1, 1'b0);

    // Handshake: start held 20 cycles, operands scrambled mid-RUN; 5*6+3 = 33
    start_op(4'd5, 4'd6, 4'd3, 1'b0);
    finish_op(8'd33, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      chk("hold_flags", uio_out, 8'h40);
      chk("hold_uo",    uo_out,  8'd33);
    end
    // Start low one cycle, then retrigger: 2*2+1 = 5, done clears at capture
    start_op(4'd2, 4'd2, 4'd1, 1'b0);
    finish_op(8'd5, 1'b0, 1'b0);

    // Enable dropped 3 cycles before RUN step 2: 6*7+4 = 46
    start_op(4'd6, 4'd7, 4'd4, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      uio_in[4] = 1'b0;
      @(posedge clk);
      #1;
      chk("ena_run", {6'b0, uio_out[6:5]}, 8'h01);
    end
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("ena_frozen_flags", {6'b0, uio_out[6:5]}, 8'h01);
      chk("ena_frozen_uo",    uo_out,               prev_res);
    end
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1;
    chk("ena_step2_flags", {6'b0, uio_out[6:5]}, 8'h01);
    @(posedge clk);
    #1;
    chk("ena_res",   uo_out,  8'd46);
    chk("ena_flags", uio_out, 8'h40);
    prev_res = 8'd46;

    // Asynchronous reset mid-RUN, then 2*5+1 = 11
    start_op(4'd3, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    uio_in[4] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_uo",  uo_out,  8'h00);
    chk("arst_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    prev_res = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_uio", uio_out, 8'h00);
      chk("post_rst_uo",  uo_out,  8'h00);
    end
    start_op(4'd2, 4'd5, 4'd1, 1'b0);
    finish_op(8'd11, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_multiplier_seq.md
# int_multiplier_seq

Sequential 4x4 shift-add multiplier with remainder add, the inverse of the team's integer divider. It rebuilds a dividend as `quotient * divisor + remainder`, so the divider's outputs can be fed back and checked on silicon. It sits in the same Tiny Tapeout user-project slot style, with dedicated, bidirectional and enable pins. A level start/done handshake runs on `uio` pins.

## Interface
- No parameters; operand width fixed at 4 bits, result width 8 bits.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable; when 0 all state holds.
- `ui_in`  in  8  [7:4] = A (quotient / multiplier), [3:0] = B (divisor / multiplicand).
- `uio_in`  in  8  [3:0] = R (remainder), [4] = start (level), [7:5] unused.
- `uo_out`  out  8  result register, `A*B + R`.
- `uio_out`  out  8  [5] = busy, [6] = done, [7] = err, [4:0] = 0.
- `uio_oe`  out  8  constant 8'b1110_0000 (bits 7:5 driven, 4:0 input).

## Operation
- States: IDLE, RUN, WAIT.
- **IDLE**
  - On `start=1` and `ena=1`, capture A, B and R into internal registers.
  - Set acc = {4'b0, R}, count = 0, busy = 1, done = 0.
  - Compute err = (B == 0) | (R >= B) from the captured values.
  - Go to RUN.
- **RUN**, one step per clock, count 0..3:
  - If A[count], acc += {4'b0, B} << count; count++.
  - After step count = 3: `uo_out` <= final acc, busy = 0, done = 1, go to WAIT.
- **WAIT**
  - Stay while start = 1.
  - On start = 0, go to IDLE.
  - done and `uo_out` keep their values.
- done clears only when the next start is accepted in IDLE.
- Arithmetic rules:
  - acc is 8 bits unsigned; max 15*15 + 15 = 240, so no overflow is possible and no overflow flag exists.
  - Shifted partial products are zero-extended to 8 bits.
- err is an advisory flag that the triple is not a valid division result. The result is still computed; with B = 0 the result equals R.
- err holds until the next accepted start.
- During RUN:
  - start is ignored.
  - Changes on `ui_in` / `uio_in` are ignored; only the captured registers are used.
- Holding start high through completion yields exactly one computation. Start must go low (WAIT to IDLE) before it can retrigger.
- `ena = 0` freezes state, count, acc and outputs. Operation resumes where it stopped when `ena` returns to 1.
- Reset, asynchronous, any state (including mid-RUN):
  - Clears to IDLE; the computation is aborted with no done.
  - `uo_out` = 0, busy = 0, done = 0, err = 0, acc = 0, count = 0.

## Timing
- Edge E0: start sampled high in IDLE. busy = 1 after E0.
- Edges E1–E4: four RUN steps.
- After E4: `uo_out` valid, done = 1, busy = 0. Latency is 4 clocks from the capture edge to valid result.
- `uo_out` changes only at the completion edge; during RUN it shows the previous result.
- busy and done are never 1 together.
- Minimum start-to-start period is 6 clocks: E0 capture, E1–E4 RUN, start low sampled in WAIT, new capture in IDLE.
- Outputs are registered; no combinational path from inputs to `uo_out` or `uio_out`.
- `uio_oe` is combinational constant, independent of reset.

## Test plan
- **Basic:** A = 7, B = 3, R = 2, start pulse.
  - busy = 1 on E1–E4.
  - After E4: `uo_out` = 23 (0x17), done = 1, err = 0.
- **Max:** A = 15, B = 15, R = 14.
  - `uo_out` = 239 (0xEF), err = 0.
  - Then A = 15, B = 15, R = 15: `uo_out` = 240, err = 1.
- **Invalid triples:**
  - A = 4, B = 3, R = 5: `uo_out` = 17, err = 1.
  - A = 9, B = 0, R = 6: `uo_out` = 6, err = 1.
- **Handshake:**
  - Hold start high 20 cycles with operands changing mid-RUN: exactly one result, from the captured operands. done stays 1, busy never re-asserts.
  - Drop start for 1 cycle, then raise it: new run starts and done clears.
- **Enable:** drop `ena` for 3 cycles during RUN step 2.
  - Result is correct.
  - done arrives exactly 3 cycles later than nominal.
- **Reset:**
  - Assert `rst_n` = 0 asynchronously mid-RUN: all outputs 0 immediately, no done.
  - After release, a new start (A = 2, B = 5, R = 1) gives 11.
